// File: rtl/nco_pkg.sv
// Shared constants, types and elaboration-time helpers for the quadrature NCO.
// The LUT contents are computed here so the ROM can be built without simulation-only code.
package nco_pkg;

    localparam int unsigned LFSR_WIDTH  = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 in shift-right form: feedback = s[0]^s[2]^s[3]^s[5], enters at the MSB.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'h002D;
    localparam int unsigned NCO_LATENCY = 3;

    typedef enum logic [1:0] {
        Quad0 = 2'd0,
        Quad1 = 2'd1,
        Quad2 = 2'd2,
        Quad3 = 2'd3
    } quadrant_e;

    function automatic int amplitude(input int unsigned width);
        return (1 << (width - 1)) - 1;
    endfunction

    // round(amp * sin(pi/2 * i/qn)) evaluated with a Taylor series so it folds to a constant.
    function automatic int quarter_sine(input int i, input int qn, input int amp);
        real x;
        real term;
        real sum;
        x    = 1.5707963267948966 * real'(i) / real'(qn);
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return $rtoi(real'(amp) * sum + 0.5);
    endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// Dual-read quarter-wave sine magnitude ROM with registered outputs.
// Entries 0..N/4 inclusive, so the peak at index N/4 is stored exactly.
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned OUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-2:0] idx_a,
    input  logic [ADDR_WIDTH-2:0] idx_b,
    output logic [OUT_WIDTH-1:0]  mag_a,
    output logic [OUT_WIDTH-1:0]  mag_b
);

    localparam int unsigned QN  = 2 ** (ADDR_WIDTH - 2);
    localparam int          AMP = amplitude(OUT_WIDTH);

    logic [OUT_WIDTH-1:0] rom [QN+1];

    for (genvar i = 0; i <= int'(QN); i++) begin : g_rom
        localparam int Val = (i == int'(QN)) ? AMP : quarter_sine(i, int'(QN), AMP);
        assign rom[i] = OUT_WIDTH'(Val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a <= '0;
            mag_b <= '0;
        end else begin
            mag_a <= rom[idx_a];
            mag_b <= rom[idx_b];
        end
    end

endmodule

// File: rtl/nco_iq.sv
// Quadrature NCO: phase accumulator, offset and optional LFSR dither, then a
// three-stage pipeline (phase, quarter-wave LUT read, sign restore) to sin/cos.
module nco_iq
    import nco_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter bit          DITHER_EN   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          phase_clr,
    input  logic        [PHASE_WIDTH-1:0] step,
    input  logic        [PHASE_WIDTH-1:0] phase_offset,
    output logic                          out_valid,
    output logic signed [OUT_WIDTH-1:0]   sin_out,
    output logic signed [OUT_WIDTH-1:0]   cos_out
);

    localparam int unsigned QN = 2 ** (ADDR_WIDTH - 2);
    localparam int unsigned IW = ADDR_WIDTH - 1;
    localparam int unsigned FW = PHASE_WIDTH - ADDR_WIDTH;
    localparam int unsigned DW = (FW < LFSR_WIDTH) ? FW : LFSR_WIDTH;

    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] dith, ph_full;
    logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [ADDR_WIDTH-1:0]  ph_q, addr_c;
    logic [IW-1:0]          idx_s, idx_c;
    logic [OUT_WIDTH-1:0]   mag_s, mag_c;
    logic                   neg_s_q, neg_c_q;
    logic [NCO_LATENCY-1:0] vld_q;
    logic                   unused_frac;

    // Quadrants 1 and 3 read the quarter table backwards.
    function automatic logic [IW-1:0] fold_idx(input logic [ADDR_WIDTH-1:0] a);
        quadrant_e     quad;
        logic [IW-1:0] q;
        quad = quadrant_e'(a[ADDR_WIDTH-1 -: 2]);
        q    = {1'b0, a[ADDR_WIDTH-3:0]};
        if (quad == Quad1 || quad == Quad3) begin
            return IW'(QN) - q;
        end
        return q;
    endfunction

    function automatic logic is_neg(input logic [ADDR_WIDTH-1:0] a);
        quadrant_e quad;
        quad = quadrant_e'(a[ADDR_WIDTH-1 -: 2]);
        return (quad == Quad2) || (quad == Quad3);
    endfunction

    always_comb begin
        acc_d = acc_q;
        if (phase_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + step;
        end
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[LFSR_WIDTH-1:1]};
        end
    end

    assign dith        = DITHER_EN ? PHASE_WIDTH'(lfsr_q[DW-1:0]) : '0;
    assign ph_full     = acc_q + phase_offset + dith;
    // Fractional phase bits are dropped by truncation to the table address.
    assign unused_frac = ^ph_full[FW-1:0];
    assign addr_c      = ph_q + ADDR_WIDTH'(QN);
    assign idx_s       = fold_idx(ph_q);
    assign idx_c       = fold_idx(addr_c);

    nco_quarter_lut #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .idx_a (idx_s),
        .idx_b (idx_c),
        .mag_a (mag_s),
        .mag_b (mag_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            ph_q    <= '0;
            neg_s_q <= 1'b0;
            neg_c_q <= 1'b0;
            vld_q   <= '0;
            sin_out <= '0;
            cos_out <= '0;
        end else begin
            acc_q   <= acc_d;
            lfsr_q  <= lfsr_d;
            ph_q    <= ph_full[PHASE_WIDTH-1 -: ADDR_WIDTH];
            neg_s_q <= is_neg(ph_q);
            neg_c_q <= is_neg(addr_c);
            vld_q   <= {vld_q[NCO_LATENCY-2:0], en};
            sin_out <= neg_s_q ? -mag_s : mag_s;
            cos_out <= neg_c_q ? -mag_c : mag_c;
        end
    end

    assign out_valid = vld_q[NCO_LATENCY-1];

endmodule

// File: tb/tb_nco_iq.sv
// Self-checking bench for nco_iq: a plain-arithmetic phase/sine model drives the expectations
// for an undithered instance and a dithered instance sharing the same stimulus.
module tb_nco_iq;

    localparam int unsigned MASK  = 32'h00FF_FFFF;
    localparam int unsigned FMASK = 32'h0000_3FFF;
    localparam int          AMP   = 32767;
    localparam real         PI    = 3.14159265358979323846;

    typedef struct {
        bit          zero;
        int unsigned ph;
        int unsigned ph_d;
        bit          v;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               en = 1'b0;
    logic               phase_clr = 1'b0;
    logic        [23:0] step = '0;
    logic        [23:0] phase_offset = '0;
    logic               vld, vld_d;
    logic signed [15:0] sin_o, cos_o, sin_d, cos_d;

    int          total = 0;
    int          bad = 0;
    ent_t        hist[$];
    int unsigned m_acc;
    bit   [15:0] m_lfsr;
    bit          exp_v;
    int          exp_sin, exp_cos, exp_sin_d, exp_cos_d;
    real         exp_ideal;

    nco_iq #(.PHASE_WIDTH(24), .ADDR_WIDTH(10), .OUT_WIDTH(16), .DITHER_EN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr), .step(step),
        .phase_offset(phase_offset), .out_valid(vld), .sin_out(sin_o), .cos_out(cos_o)
    );

    nco_iq #(.PHASE_WIDTH(24), .ADDR_WIDTH(10), .OUT_WIDTH(16), .DITHER_EN(1'b1)) dut_d (
        .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr), .step(step),
        .phase_offset(phase_offset), .out_valid(vld_d), .sin_out(sin_d), .cos_out(cos_d)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ideal full-circle sample at the truncated 10-bit address of a 24-bit phase.
    function automatic int ideal_sample(input int unsigned ph, input bit is_cos);
        int unsigned a;
        real         ang;
        real         y;
        a   = (ph >> 14) & 32'd1023;
        ang = 2.0 * PI * real'(a) / 1024.0;
        y   = real'(AMP) * (is_cos ? $cos(ang) : $sin(ang));
        return (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(-y + 0.5);
    endfunction

    task automatic model_reset();
        ent_t z;
        m_acc  = 0;
        m_lfsr = 16'hACE1;
        hist.delete();
        z.zero = 1'b1; z.ph = 0; z.ph_d = 0; z.v = 1'b0;
        hist.push_back(z);
        z.zero = 1'b0;
        hist.push_back(z);
    endtask

    task automatic model_edge();
        ent_t e;
        ent_t x;
        bit   fb;
        e.zero = 1'b0;
        e.ph   = (m_acc + 32'(phase_offset)) & MASK;
        e.ph_d = (m_acc + 32'(phase_offset) + (32'(m_lfsr) & FMASK)) & MASK;
        e.v    = en;
        hist.push_back(e);
        x     = hist.pop_front();
        exp_v = x.v;
        if (x.zero) begin
            exp_sin = 0; exp_cos = 0; exp_sin_d = 0; exp_cos_d = 0; exp_ideal = 0.0;
        end else begin
            exp_sin   = ideal_sample(x.ph, 1'b0);
            exp_cos   = ideal_sample(x.ph, 1'b1);
            exp_sin_d = ideal_sample(x.ph_d, 1'b0);
            exp_cos_d = ideal_sample(x.ph_d, 1'b1);
            exp_ideal = real'(AMP) * $sin(2.0 * PI * real'(x.ph) / 16777216.0);
        end
        if (en) begin
            fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
            m_lfsr = {fb, m_lfsr[15:1]};
        end
        if (phase_clr) m_acc = 0;
        else if (en)   m_acc = (m_acc + 32'(step)) & MASK;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        if ({vld, vld_d} !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b want=00", {vld, vld_d}); end
        total++;
        if (sin_o !== 16'sd0 || cos_o !== 16'sd0) begin bad++; $display("FAIL reset_out got=%0d/%0d want=0/0", sin_o, cos_o); end
        total++;
        if (sin_d !== 16'sd0 || cos_d !== 16'sd0) begin bad++; $display("FAIL reset_out_d got=%0d/%0d want=0/0", sin_d, cos_d); end
        total++;
        tick();
        tick();
        #2 rst_n = 1'b1;
        en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (vld !== exp_v) begin bad++; $display("FAIL idle_valid k=%0d got=%b want=%b", k, vld, exp_v); end
            total++;
            if (int'(sin_o) != exp_sin || int'(cos_o) != exp_cos) begin
                bad++; $display("FAIL idle_out k=%0d got=%0d/%0d want=%0d/%0d", k, sin_o, cos_o, exp_sin, exp_cos);
            end
            total++;
        end
    endtask

    task automatic test_quarter(input logic [23:0] off, input int sgn);
        int ps[4];
        int pc[4];
        ps = '{0, 32767, 0, -32767};
        pc = '{32767, 0, -32767, 0};
        do_reset();
        step = 24'h400000; phase_offset = off; phase_clr = 1'b0; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (vld !== exp_v || vld !== (k >= 3)) begin
                bad++; $display("FAIL quarter_valid off=%h k=%0d got=%b want=%b", off, k, vld, k >= 3);
            end
            total++;
            if (k >= 3) begin
                if (int'(sin_o) != sgn * ps[(k-3)%4] || int'(cos_o) != sgn * pc[(k-3)%4]) begin
                    bad++; $display("FAIL quarter_out off=%h k=%0d got=%0d/%0d want=%0d/%0d", off, k,
                                    sin_o, cos_o, sgn * ps[(k-3)%4], sgn * pc[(k-3)%4]);
                end
                total++;
            end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap();
        int prev;
        int d;
        do_reset();
        step = 24'hFFC000; phase_offset = '0; en = 1'b1;
        prev = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            d = int'(sin_o) - exp_sin;
            if (d > 1 || d < -1 || int'(cos_o) - exp_cos > 1 || int'(cos_o) - exp_cos < -1) begin
                bad++; $display("FAIL wrap_model k=%0d got=%0d/%0d want=%0d/%0d", k, sin_o, cos_o, exp_sin, exp_cos);
            end
            total++;
            if (k == 4) begin
                if (sin_o !== -16'sd201) begin bad++; $display("FAIL wrap_first_step got=%0d want=-201", sin_o); end
                total++;
            end
            if (k >= 4) begin
                d = int'(sin_o) - prev;
                if (d > 202 || d < -202) begin bad++; $display("FAIL wrap_jump k=%0d got=%0d want<=202", k, d); end
                total++;
            end
            prev = int'(sin_o);
        end
        en = 1'b0;
    endtask

    task automatic test_clear();
        int d;
        do_reset();
        step = 24'h123456; phase_offset = '0; en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            phase_clr = (k == 8);
            tick();
            if (k >= 3) begin
                if (vld !== 1'b1) begin bad++; $display("FAIL clear_valid k=%0d got=%b want=1", k, vld); end
                total++;
            end
            d = int'(sin_o) - exp_sin;
            if (d > 1 || d < -1) begin bad++; $display("FAIL clear_model k=%0d got=%0d want=%0d", k, sin_o, exp_sin); end
            total++;
            if (k == 11) begin
                if (sin_o !== 16'sd0 || cos_o !== 16'sd32767) begin
                    bad++; $display("FAIL clear_out got=%0d/%0d want=0/32767", sin_o, cos_o);
                end
                total++;
            end
        end
        phase_clr = 1'b0; en = 1'b0;
    endtask

    task automatic test_en_gap();
        bit pat[14];
        int ps[4];
        int nval;
        bit want;
        pat  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0};
        ps   = '{0, 32767, 0, -32767};
        nval = 0;
        do_reset();
        step = 24'h400000; phase_offset = '0;
        for (int k = 1; k <= 14; k++) begin
            en = pat[k-1];
            tick();
            want = (k >= 3) ? pat[k-3] : 1'b0;
            if (vld !== want) begin bad++; $display("FAIL gap_valid k=%0d got=%b want=%b", k, vld, want); end
            total++;
            if (vld === 1'b1) begin
                if (int'(sin_o) != ps[nval%4]) begin
                    bad++; $display("FAIL gap_seq n=%0d got=%0d want=%0d", nval, sin_o, ps[nval%4]);
                end
                total++;
                nval++;
            end
        end
        if (nval != 9) begin bad++; $display("FAIL gap_count got=%0d want=9", nval); end
        total++;
        en = 1'b0;
    endtask

    task automatic test_random();
        int d0, d1, d2, d3;
        do_reset();
        for (int k = 1; k <= 400; k++) begin
            en        = ($urandom_range(0, 3) != 0);
            phase_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) step = 24'($urandom);
            if (k % 50 == 1) phase_offset = 24'($urandom);
            tick();
            if (vld !== exp_v || vld_d !== exp_v) begin
                bad++; $display("FAIL rand_valid k=%0d got=%b/%b want=%b", k, vld, vld_d, exp_v);
            end
            total++;
            d0 = int'(sin_o) - exp_sin;
            d1 = int'(cos_o) - exp_cos;
            d2 = int'(sin_d) - exp_sin_d;
            d3 = int'(cos_d) - exp_cos_d;
            if (d0 > 1 || d0 < -1 || d1 > 1 || d1 < -1) begin
                bad++; $display("FAIL rand_out k=%0d got=%0d/%0d want=%0d/%0d", k, sin_o, cos_o, exp_sin, exp_cos);
            end
            total++;
            if (d2 > 1 || d2 < -1 || d3 > 1 || d3 < -1) begin
                bad++; $display("FAIL rand_out_d k=%0d got=%0d/%0d want=%0d/%0d", k, sin_d, cos_d, exp_sin_d, exp_cos_d);
            end
            total++;
        end
        en = 1'b0; phase_clr = 1'b0;
    endtask

    task automatic test_async_dither();
        int  d;
        real e;
        do_reset();
        step = 24'h000100; phase_offset = '0; en = 1'b1;
        for (int k = 1; k <= 20; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        if ({vld, vld_d} !== 2'b00) begin bad++; $display("FAIL async_valid got=%b want=00", {vld, vld_d}); end
        total++;
        if (sin_o !== 16'sd0 || cos_o !== 16'sd0 || sin_d !== 16'sd0 || cos_d !== 16'sd0) begin
            bad++; $display("FAIL async_out got=%0d/%0d/%0d/%0d want=0", sin_o, cos_o, sin_d, cos_d);
        end
        total++;
        tick();
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k <= 3) begin
                if (vld_d !== (k == 3)) begin bad++; $display("FAIL async_restart k=%0d got=%b want=%b", k, vld_d, k == 3); end
                total++;
            end
            d = int'(sin_d) - exp_sin_d;
            if (d > 1 || d < -1) begin bad++; $display("FAIL dither_model k=%0d got=%0d want=%0d", k, sin_d, exp_sin_d); end
            total++;
            if (exp_v) begin
                e = real'(int'(sin_d)) - exp_ideal;
                if (e > 202.0 || e < -202.0) begin
                    bad++; $display("FAIL dither_err k=%0d got=%0d ideal=%f", k, sin_d, exp_ideal);
                end
                total++;
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_quarter(24'h000000, 1);
        test_quarter(24'h800000, -1);
        test_wrap();
        test_clear();
        test_en_gap();
        test_random();
        test_async_dither();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
